// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions between fetch and execute.
// Pops the oldest prediction on each resolve, detects mispredicts, drives
// the BHT update port and raises a one-cycle flush with the corrected PC.
module branch_resolve_queue #(
  parameter int unsigned WIDTH_PC = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_valid,
  input  logic [WIDTH_PC-1:0]       push_pc,
  input  logic                      push_hit,
  input  logic                      push_jump,
  input  logic [WIDTH_PC-1:0]       push_target,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      resolve_valid,
  input  logic                      resolve_taken,
  input  logic [WIDTH_PC-1:0]       resolve_target,
  output logic                      flush,
  output logic [WIDTH_PC-1:0]       redirect_pc,
  output logic                      upd_valid,
  output logic                      upd_wrong,
  output logic [WIDTH_PC-1:0]       upd_pc,
  output logic [15:0]               br_cnt,
  output logic [15:0]               miss_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Prediction storage; no reset needed, validity is tracked by count_q
  logic [WIDTH_PC-1:0] pc_mem  [DEPTH];
  logic [WIDTH_PC-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0]    hit_mem;
  logic [DEPTH-1:0]    jump_mem;

  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                flush_q, flush_d;
  logic [WIDTH_PC-1:0] redirect_q, redirect_d;
  logic                upd_valid_q, upd_valid_d, upd_wrong_q, upd_wrong_d;
  logic [WIDTH_PC-1:0] upd_pc_q, upd_pc_d;
  logic [15:0]         br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  logic                resolve_act, push_act, mispredict, pred_taken;
  logic [WIDTH_PC-1:0] ent_pc, ent_tgt;

  assign ent_pc  = pc_mem[rd_ptr_q];
  assign ent_tgt = tgt_mem[rd_ptr_q];

  // Evaluate the oldest entry against the execute outcome and compute next state
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    full_d      = full_q;
    empty_d     = empty_q;
    flush_d     = 1'b0;
    redirect_d  = redirect_q;
    upd_valid_d = 1'b0;
    upd_wrong_d = 1'b0;
    upd_pc_d    = upd_pc_q;
    br_cnt_d    = br_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    // In the flush cycle the queue is already empty and execute is being killed
    resolve_act = resolve_valid & ~empty_q & ~flush_q;
    pred_taken  = hit_mem[rd_ptr_q] & jump_mem[rd_ptr_q];
    mispredict  = resolve_act &
                  ((pred_taken != resolve_taken) |
                   (pred_taken & resolve_taken & (ent_tgt != resolve_target)));
    push_act    = push_valid & ~full_q & ~mispredict & ~flush_q;

    if (resolve_act) begin
      upd_valid_d = 1'b1;
      upd_wrong_d = mispredict;
      upd_pc_d    = resolve_taken ? resolve_target : ent_pc;
      if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
    end

    if (mispredict) begin
      flush_d    = 1'b1;
      redirect_d = resolve_taken ? resolve_target : ent_pc + WIDTH_PC'(4);
      if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      full_d     = 1'b0;
      empty_d    = 1'b1;
    end else begin
      if (push_act)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (resolve_act) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_act) - CNT_W'(resolve_act);
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_wrong_q <= 1'b0;
      upd_pc_q    <= '0;
      br_cnt_q    <= '0;
      miss_cnt_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      upd_valid_q <= upd_valid_d;
      upd_wrong_q <= upd_wrong_d;
      upd_pc_q    <= upd_pc_d;
      br_cnt_q    <= br_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Write accepted predictions into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (!rst && push_act) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      tgt_mem[wr_ptr_q]  <= push_target;
      hit_mem[wr_ptr_q]  <= push_hit;
      jump_mem[wr_ptr_q] <= push_jump;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign upd_valid   = upd_valid_q;
  assign upd_wrong   = upd_wrong_q;
  assign upd_pc      = upd_pc_q;
  assign br_cnt      = br_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (WIDTH_PC=32, DEPTH=4).
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid, push_hit, push_jump;
  logic [31:0] push_pc, push_target;
  logic        full, empty;
  logic [2:0]  count;
  logic        resolve_valid, resolve_taken;
  logic [31:0] resolve_target;
  logic        flush, upd_valid, upd_wrong;
  logic [31:0] redirect_pc, upd_pc;
  logic [15:0] br_cnt, miss_cnt;

  int checks = 0;
  int passed = 0;

  branch_resolve_queue #(.WIDTH_PC(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_hit(push_hit),
    .push_jump(push_jump), .push_target(push_target),
    .full(full), .empty(empty), .count(count),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_wrong(upd_wrong), .upd_pc(upd_pc),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  // One clock with the given push/resolve inputs, then sample #1 after the edge
  task automatic cyc(input logic pv, input logic [31:0] ppc, input logic ph, input logic pj,
                     input logic [31:0] pt, input logic rv, input logic rt, input logic [31:0] rtgt);
    push_valid = pv; push_pc = ppc; push_hit = ph; push_jump = pj; push_target = pt;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt;
    @(posedge clk); #1;
    push_valid = 1'b0; resolve_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] ppc, input logic ph, input logic pj, input logic [31:0] pt);
    cyc(1'b1, ppc, ph, pj, pt, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtgt);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, rt, rtgt);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    push_valid = 1'b0; push_pc = '0; push_hit = 1'b0; push_jump = 1'b0; push_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_pc", upd_pc, 32'h0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_br_cnt", 32'(br_cnt), 32'd0);

    // 1: correct taken prediction
    push(32'h100, 1'b1, 1'b1, 32'h200);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_empty", 32'(empty), 32'd0);
    resolve(1'b1, 32'h200);
    chk("t1_upd_valid", 32'(upd_valid), 32'd1);
    chk("t1_upd_wrong", 32'(upd_wrong), 32'd0);
    chk("t1_upd_pc", upd_pc, 32'h200);
    chk("t1_flush", 32'(flush), 32'd0);
    chk("t1_empty_after", 32'(empty), 32'd1);
    chk("t1_br_cnt", 32'(br_cnt), 32'd1);

    // 2: predicted not-taken, actually taken
    push(32'h104, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 32'h180);
    chk("t2_flush", 32'(flush), 32'd1);
    chk("t2_redirect", redirect_pc, 32'h180);
    chk("t2_upd_wrong", 32'(upd_wrong), 32'd1);
    chk("t2_upd_pc", upd_pc, 32'h180);
    chk("t2_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("t2_br_cnt", 32'(br_cnt), 32'd2);
    idle();
    chk("t2_flush_pulse", 32'(flush), 32'd0);
    chk("t2_upd_valid_pulse", 32'(upd_valid), 32'd0);
    chk("t2_redirect_hold", redirect_pc, 32'h180);

    // 3: fill, overflow push dropped, drain in order
    push(32'h010, 1'b1, 1'b0, 32'h999);
    push(32'h014, 1'b1, 1'b0, 32'h999);
    push(32'h018, 1'b1, 1'b0, 32'h999);
    chk("t3_full_early", 32'(full), 32'd0);
    push(32'h01C, 1'b1, 1'b0, 32'h999);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count4", 32'(count), 32'd4);
    push(32'h020, 1'b1, 1'b0, 32'h999);
    chk("t3_count_drop", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0, 32'h0);
      chk($sformatf("t3_upd_valid%0d", i), 32'(upd_valid), 32'd1);
      chk($sformatf("t3_upd_wrong%0d", i), 32'(upd_wrong), 32'd0);
      chk($sformatf("t3_upd_pc%0d", i), upd_pc, 32'h010 + 32'(4 * i));
    end
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_br_cnt", 32'(br_cnt), 32'd6);

    // 4: mispredict on oldest of three clears queue; pushes in N and N+1 dropped
    push(32'h300, 1'b1, 1'b1, 32'h340);
    push(32'h308, 1'b1, 1'b0, 32'h0);
    push(32'h30C, 1'b1, 1'b0, 32'h0);
    chk("t4_count3", 32'(count), 32'd3);
    cyc(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t4_flush", 32'(flush), 32'd1);
    chk("t4_redirect", redirect_pc, 32'h304);
    chk("t4_count0", 32'(count), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_upd_pc", upd_pc, 32'h300);
    chk("t4_miss_cnt", 32'(miss_cnt), 32'd2);
    cyc(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    chk("t4_flush_push_count", 32'(count), 32'd0);
    chk("t4_flush_resolve_ign", 32'(upd_valid), 32'd0);
    chk("t4_flush_off", 32'(flush), 32'd0);
    chk("t4_br_cnt", 32'(br_cnt), 32'd7);

    // 5: full with simultaneous push+resolve, then wrap with count held at 2
    push(32'h700, 1'b0, 1'b0, 32'h0);
    push(32'h704, 1'b0, 1'b0, 32'h0);
    push(32'h708, 1'b0, 1'b0, 32'h0);
    push(32'h70C, 1'b0, 1'b0, 32'h0);
    chk("t5_full", 32'(full), 32'd1);
    cyc(1'b1, 32'h710, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t5_count3", 32'(count), 32'd3);
    chk("t5_upd_pc0", upd_pc, 32'h700);
    resolve(1'b0, 32'h0);
    chk("t5_count2", 32'(count), 32'd2);
    chk("t5_upd_pc1", upd_pc, 32'h704);
    cyc(1'b1, 32'h718, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t5_count_hold", 32'(count), 32'd2);
    chk("t5_upd_pc2", upd_pc, 32'h708);
    resolve(1'b0, 32'h0);
    chk("t5_upd_pc3", upd_pc, 32'h70C);
    resolve(1'b0, 32'h0);
    chk("t5_upd_pc_wrap", upd_pc, 32'h718);
    chk("t5_upd_wrong", 32'(upd_wrong), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_br_cnt", 32'(br_cnt), 32'd12);

    // taken with wrong target is a mispredict
    push(32'h800, 1'b1, 1'b1, 32'h900);
    resolve(1'b1, 32'h904);
    chk("tt_flush", 32'(flush), 32'd1);
    chk("tt_redirect", redirect_pc, 32'h904);
    chk("tt_upd_wrong", 32'(upd_wrong), 32'd1);
    chk("tt_miss_cnt", 32'(miss_cnt), 32'd3);
    idle();

    // 6: resolve while empty is ignored
    resolve(1'b1, 32'h123);
    chk("t6_upd_valid", 32'(upd_valid), 32'd0);
    chk("t6_br_cnt", 32'(br_cnt), 32'd13);
    chk("t6_upd_pc_hold", upd_pc, 32'h904);

    // 6: reset mid-queue wins over a concurrent push/resolve
    push(32'hA00, 1'b0, 1'b0, 32'h0);
    push(32'hA04, 1'b0, 1'b0, 32'h0);
    push(32'hA08, 1'b1, 1'b1, 32'h0);
    chk("t6_count3", 32'(count), 32'd3);
    rst = 1'b1;
    cyc(1'b1, 32'hB00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h50);
    rst = 1'b0;
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_full", 32'(full), 32'd0);
    chk("t6_rst_flush", 32'(flush), 32'd0);
    chk("t6_rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("t6_rst_upd_pc", upd_pc, 32'h0);
    chk("t6_rst_redirect", redirect_pc, 32'h0);
    chk("t6_rst_br_cnt", 32'(br_cnt), 32'd0);
    chk("t6_rst_miss_cnt", 32'(miss_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
